note_voice_envelope: RTL and testbench
======================================

NOTE_VOICE_ENVELOPE -- requirements
Module: note_voice_envelope

Interface
REQ-001 Parameter PHASE_W, 16, phase-increment width; SHALL equal the frequency-ROM data width.
REQ-002 Parameter VOL_MAX, 15, full-scale volume; o_volume is 4 bits.
REQ-003 i_clk  in  1  sole clock; all state SHALL change on its rising edge.
REQ-004 i_rst_n  in  1  reset, asynchronous, active-low.
REQ-005 i_note_valid  in  1  one-cycle pulse: new note event from the upstream note sequencer.
REQ-006 i_note  in  6  note code; 0 = rest, 1..63 = pitch index.
REQ-007 i_instrument  in  4  [1:0] attack-rate select, [3:2] release-rate select.
REQ-008 i_frame_stb  in  1  one-cycle envelope step tick.
REQ-009 o_freq_rom_addr  out  6  registered address to the external period ROM.
REQ-010 i_freq_rom_data  in  PHASE_W  ROM data, valid one cycle after the address is presented (synchronous ROM).
REQ-011 o_phase_inc  out  PHASE_W  phase increment for the oscillator.
REQ-012 o_volume  out  4  current envelope level.
REQ-013 o_gate  out  1  high while in ATTACK or SUSTAIN.
REQ-014 o_busy  out  1  high in any state other than IDLE.

Function
REQ-015 States SHALL be IDLE, LOOKUP, LOAD, ATTACK, SUSTAIN, RELEASE.
REQ-016 i_note_valid with i_note!=0, any state: latch note and instrument; o_freq_rom_addr<=i_note; next state LOOKUP.
REQ-017 LOOKUP -> LOAD unconditionally after one cycle.
REQ-018 LOAD: o_phase_inc<=i_freq_rom_data, o_volume<=0; next state ATTACK; o_phase_inc SHALL therefore update on the second rising edge after the edge sampling i_note_valid.
REQ-019 Attack step SHALL be 1+attack_sel (1..4); release step 1+release_sel (1..4), both from the latched instrument.
REQ-020 ATTACK, on i_frame_stb: o_volume<=min(o_volume+step, VOL_MAX); go SUSTAIN on the same edge the result equals VOL_MAX.
REQ-021 SUSTAIN: o_volume holds VOL_MAX; i_frame_stb ignored.
REQ-022 i_note_valid with i_note==0 (rest): if o_volume==0 go IDLE, otherwise go RELEASE; o_freq_rom_addr and o_phase_inc SHALL be unchanged.
REQ-023 RELEASE, on i_frame_stb: o_volume<=max(o_volume-step, 0); on reaching 0 go IDLE and clear o_phase_inc to 0 on the same edge.
REQ-024 IDLE: o_volume=0, o_phase_inc=0, o_gate=0.
REQ-025 i_frame_stb during LOOKUP or LOAD SHALL be ignored (no volume change, no queueing).
REQ-026 i_note_valid coincident with i_frame_stb SHALL be handled as the note event only; the frame step is dropped.
REQ-027 A new pitched note during LOOKUP/LOAD SHALL restart LOOKUP with the newest note; the older note is discarded.
REQ-028 Retrigger from ATTACK/SUSTAIN/RELEASE SHALL restart from volume 0 (hard retrigger); o_volume drops to 0 only at LOAD, holding its old value through LOOKUP.
REQ-029 All volume arithmetic SHALL be done at 5 bits and saturated; o_volume SHALL never wrap.

Reset
REQ-030 While i_rst_n=0: state IDLE, o_freq_rom_addr=0, o_phase_inc=0, o_volume=0, o_gate=0, o_busy=0, latched instrument=0.
REQ-031 Reset assertion mid-envelope SHALL take effect immediately without a clock; deassertion is synchronised externally, and the first event accepted is on the first edge with i_rst_n=1.

Verification
REQ-032 Note 12, instrument 0x0, ROM[12]=0x1234 -> o_phase_inc=0x1234 two edges after the valid edge; o_gate=1; volume rises 1 per frame_stb, reaching 15 after 15 strobes, then SUSTAIN.
REQ-033 Instrument 0x3 (attack step 4) -> volume sequence 4,8,12,15, SUSTAIN on the 4th strobe.
REQ-034 From SUSTAIN, rest note with release step 4 (instrument 0xC) -> volume 11,7,3,0; IDLE and o_phase_inc=0 on the 4th strobe; o_gate low from the rest edge.
REQ-035 Note 5 then note 9 one cycle later -> o_freq_rom_addr=9, o_phase_inc=ROM[9], ROM[5] never loaded; frame_stb during LOOKUP leaves volume unchanged.
REQ-036 Note valid and frame_stb same cycle in SUSTAIN -> LOOKUP, volume stays 15 until LOAD, then 0.
REQ-037 i_rst_n pulsed low mid-ATTACK between clock edges -> all outputs 0 immediately; after release, the next note behaves as in REQ-032.

Source files
------------

// File: rtl/note_voice_envelope.sv
// Single-voice note front end: fetches the phase increment from a synchronous period ROM
// and runs a linear attack/sustain/release volume envelope stepped by a frame strobe.
module note_voice_envelope #(
    parameter int unsigned PHASE_W = 16,
    parameter int unsigned VOL_MAX = 15
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_note_valid,
    input  logic [5:0]         i_note,
    input  logic [3:0]         i_instrument,
    input  logic               i_frame_stb,
    output logic [5:0]         o_freq_rom_addr,
    input  logic [PHASE_W-1:0] i_freq_rom_data,
    output logic [PHASE_W-1:0] o_phase_inc,
    output logic [3:0]         o_volume,
    output logic               o_gate,
    output logic               o_busy
);

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StLoad,
        StAttack,
        StSustain,
        StRelease
    } state_e;

    state_e             state_q, state_d;
    logic [5:0]         addr_q, addr_d;
    logic [3:0]         instr_q, instr_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [3:0]         vol_q, vol_d;

    logic [4:0] vol_up;
    logic [3:0] rel_step;

    // Attack sum kept at 5 bits so saturation can be detected before truncation.
    assign vol_up   = {1'b0, vol_q} + {3'b000, instr_q[1:0]} + 5'd1;
    assign rel_step = {2'b00, instr_q[3:2]} + 4'd1;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        instr_d = instr_q;
        phase_d = phase_q;
        vol_d   = vol_q;

        if (i_note_valid && (i_note != 6'd0)) begin
            addr_d  = i_note;
            instr_d = i_instrument;
            state_d = StLookup;
        end else if (i_note_valid) begin
            // Rest: fade out if anything is audible, otherwise fall straight to idle.
            if (vol_q == 4'd0) begin
                state_d = StIdle;
                phase_d = '0;
            end else begin
                state_d = StRelease;
            end
        end else begin
            unique case (state_q)
                StLookup: state_d = StLoad;
                StLoad: begin
                    phase_d = i_freq_rom_data;
                    vol_d   = 4'd0;
                    state_d = StAttack;
                end
                StAttack: begin
                    if (i_frame_stb) begin
                        if (vol_up >= 5'(VOL_MAX)) begin
                            vol_d   = 4'(VOL_MAX);
                            state_d = StSustain;
                        end else begin
                            vol_d = vol_up[3:0];
                        end
                    end
                end
                StRelease: begin
                    if (i_frame_stb) begin
                        if (vol_q <= rel_step) begin
                            vol_d   = 4'd0;
                            phase_d = '0;
                            state_d = StIdle;
                        end else begin
                            vol_d = vol_q - rel_step;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            addr_q  <= 6'd0;
            instr_q <= 4'd0;
            phase_q <= '0;
            vol_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            phase_q <= phase_d;
            vol_q   <= vol_d;
        end
    end

    assign o_freq_rom_addr = addr_q;
    assign o_phase_inc     = phase_q;
    assign o_volume        = vol_q;
    assign o_gate          = (state_q == StAttack) || (state_q == StSustain);
    assign o_busy          = (state_q != StIdle);

endmodule

// File: tb/tb_note_voice_envelope.sv
// Bench for note_voice_envelope: directed vector table, reset corner case, and random
// traffic compared against an event-level envelope model.
module tb_note_voice_envelope;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        note_valid = 1'b0;
    logic [5:0]  note = 6'd0;
    logic [3:0]  instrument = 4'd0;
    logic        frame_stb = 1'b0;
    logic [5:0]  rom_addr;
    logic [15:0] rom_data;
    logic [15:0] phase_inc;
    logic [3:0]  volume;
    logic        gate;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    note_voice_envelope #(.PHASE_W(16), .VOL_MAX(15)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_note_valid    (note_valid),
        .i_note          (note),
        .i_instrument    (instrument),
        .i_frame_stb     (frame_stb),
        .o_freq_rom_addr (rom_addr),
        .i_freq_rom_data (rom_data),
        .o_phase_inc     (phase_inc),
        .o_volume        (volume),
        .o_gate          (gate),
        .o_busy          (busy)
    );

    function automatic logic [15:0] rom_fn(input logic [5:0] a);
        if (a == 6'd12) return 16'h1234;
        return {a, 2'b01, a, 2'b10} ^ 16'h5A5A;
    endfunction

    always_ff @(posedge clk) rom_data <= rom_fn(rom_addr);

    // Event-level model: a pitched note waits two edges for the ROM, then the level ramps.
    typedef enum {MQuiet, MFetch, MUp, MHold, MDown} mode_e;
    mode_e m_mode;
    int m_vol, m_phase, m_addr, m_ins, m_pend;

    task automatic model_reset();
        m_mode = MQuiet; m_vol = 0; m_phase = 0; m_addr = 0; m_ins = 0; m_pend = 0;
    endtask

    task automatic model_step(input bit nv, input int nt, input int ins, input bit fs);
        if (nv && nt != 0) begin
            m_addr = nt; m_ins = ins; m_mode = MFetch; m_pend = 2;
        end else if (nv) begin
            if (m_vol == 0) begin
                m_mode = MQuiet; m_phase = 0;
            end else begin
                m_mode = MDown;
            end
        end else begin
            case (m_mode)
                MFetch: begin
                    m_pend--;
                    if (m_pend == 0) begin
                        m_phase = int'(rom_fn(6'(m_addr))); m_vol = 0; m_mode = MUp;
                    end
                end
                MUp: if (fs) begin
                    m_vol = m_vol + 1 + (m_ins % 4);
                    if (m_vol >= 15) begin m_vol = 15; m_mode = MHold; end
                end
                MDown: if (fs) begin
                    m_vol = m_vol - 1 - (m_ins / 4);
                    if (m_vol <= 0) begin m_vol = 0; m_phase = 0; m_mode = MQuiet; end
                end
                default: ;
            endcase
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        check("mdl_volume", int'(volume), m_vol);
        check("mdl_phase", int'(phase_inc), m_phase);
        check("mdl_addr", int'(rom_addr), m_addr);
        check("mdl_gate", int'(gate), int'(m_mode == MUp || m_mode == MHold));
        check("mdl_busy", int'(busy), int'(m_mode != MQuiet));
    endtask

    // Drive at negedge, model on the edge, sample 1 ns later.
    task automatic tick(input bit nv, input int nt, input int ins, input bit fs);
        note_valid = nv; note = 6'(nt); instrument = 4'(ins); frame_stb = fs;
        @(posedge clk);
        model_step(nv, nt, ins, fs);
        #1;
        check_model();
        @(negedge clk);
        note_valid = 1'b0; frame_stb = 1'b0;
    endtask

    typedef struct {
        bit nv; int nt; int ins; bit fs;
        int vol; int phase; int addr; bit g; bit b;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input bit nv, input int nt, input int ins, input bit fs,
                       input int vol, input int phase, input int addr, input bit g, input bit b);
        vec_t v;
        v.nv = nv; v.nt = nt; v.ins = ins; v.fs = fs;
        v.vol = vol; v.phase = phase; v.addr = addr; v.g = g; v.b = b;
        tbl.push_back(v);
    endtask

    initial begin
        int p3, p9;
        p3 = int'(rom_fn(6'd3));
        p9 = int'(rom_fn(6'd9));

        // Note 12 inst 0: strobes in LOOKUP/LOAD ignored, then 1 per strobe to 15.
        add(1, 12, 0, 0, 0, 0, 12, 0, 1);
        add(0, 0, 0, 1, 0, 0, 12, 0, 1);
        add(0, 0, 0, 1, 0, 'h1234, 12, 1, 1);
        for (int i = 1; i <= 15; i++) add(0, 0, 0, 1, i, 'h1234, 12, 1, 1);
        add(0, 0, 0, 1, 15, 'h1234, 12, 1, 1);
        // Note + strobe in SUSTAIN: volume holds 15 until LOAD.
        add(1, 3, 'hF, 1, 15, 'h1234, 3, 0, 1);
        add(0, 0, 0, 0, 15, 'h1234, 3, 0, 1);
        add(0, 0, 0, 0, 0, p3, 3, 1, 1);
        add(0, 0, 0, 1, 4, p3, 3, 1, 1);
        add(0, 0, 0, 1, 8, p3, 3, 1, 1);
        add(0, 0, 0, 1, 12, p3, 3, 1, 1);
        add(0, 0, 0, 1, 15, p3, 3, 1, 1);
        add(0, 0, 0, 0, 15, p3, 3, 1, 1);
        // Rest with release step 4.
        add(1, 0, 0, 0, 15, p3, 3, 0, 1);
        add(0, 0, 0, 1, 11, p3, 3, 0, 1);
        add(0, 0, 0, 1, 7, p3, 3, 0, 1);
        add(0, 0, 0, 1, 3, p3, 3, 0, 1);
        add(0, 0, 0, 1, 0, 0, 3, 0, 0);
        // Note 5 superseded by note 9 during LOOKUP.
        add(1, 5, 0, 0, 0, 0, 5, 0, 1);
        add(1, 9, 0, 1, 0, 0, 9, 0, 1);
        add(0, 0, 0, 1, 0, 0, 9, 0, 1);
        add(0, 0, 0, 0, 0, p9, 9, 1, 1);
        // Rest at zero volume goes straight to idle.
        add(1, 0, 0, 0, 0, 0, 9, 0, 0);

        model_reset();
        @(negedge clk);
        #1;
        check("rst_volume", int'(volume), 0);
        check("rst_phase", int'(phase_inc), 0);
        check("rst_addr", int'(rom_addr), 0);
        check("rst_gate", int'(gate), 0);
        check("rst_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            tick(tbl[i].nv, tbl[i].nt, tbl[i].ins, tbl[i].fs);
            check($sformatf("tbl%0d_volume", i), int'(volume), tbl[i].vol);
            check($sformatf("tbl%0d_phase", i), int'(phase_inc), tbl[i].phase);
            check($sformatf("tbl%0d_addr", i), int'(rom_addr), tbl[i].addr);
            check($sformatf("tbl%0d_gate", i), int'(gate), int'(tbl[i].g));
            check($sformatf("tbl%0d_busy", i), int'(busy), int'(tbl[i].b));
        end

        // Asynchronous reset between edges in the middle of an attack.
        tick(1, 20, 1, 0);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 1);
        check("pre_rst_volume", int'(volume), 4);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_volume", int'(volume), 0);
        check("async_phase", int'(phase_inc), 0);
        check("async_addr", int'(rom_addr), 0);
        check("async_gate", int'(gate), 0);
        check("async_busy", int'(busy), 0);
        @(posedge clk);
        #1;
        check_model();
        @(negedge clk);
        rst_n = 1'b1;
        tick(1, 12, 0, 0);
        tick(0, 0, 0, 0);
        check("post_rst_phase_early", int'(phase_inc), 0);
        tick(0, 0, 0, 0);
        check("post_rst_phase", int'(phase_inc), 'h1234);
        check("post_rst_gate", int'(gate), 1);
        tick(0, 0, 0, 1);
        check("post_rst_volume", int'(volume), 1);

        // Random traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            bit nv, fs;
            int nt;
            nv = ($urandom_range(0, 11) == 0);
            nt = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 63));
            fs = ($urandom_range(0, 2) == 0);
            tick(nv, nt, int'($urandom_range(0, 15)), fs);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
